// File: rtl/cnn_seq_pkg.sv
// Shared types and default constants for the LeNet frame sequencer.
package cnn_seq_pkg;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_RST = 2'd1,
    RUN      = 2'd2,
    REPORT   = 2'd3
  } seq_state_e;

  // Defaults matching the reference LeNet core: 32x32 half-precision input.
  localparam int unsigned LENET_PIXELS     = 1024;
  localparam int unsigned LENET_PIX_W      = 16;
  localparam int unsigned LENET_RUN_CYCLES = 75720;
  localparam int unsigned LENET_CLASSES    = 10;

  // A class index is legal when it names one of the n_classes outputs.
  function automatic logic class_legal(input logic [31:0] cls, input int unsigned n_classes);
    return cls < n_classes;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a coincident increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Hold at all-ones once reached so long runs never wrap back to a small value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lenet_frame_sequencer.sv
// Frame sequencer: latches one image, pulses the core reset, waits a fixed
// inference window, captures the class and reports it with running accuracy stats.
module lenet_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int unsigned PIXELS     = LENET_PIXELS,
  parameter int unsigned PIX_W      = LENET_PIX_W,
  parameter int unsigned LABEL_W    = 4,
  parameter int unsigned N_CLASSES  = LENET_CLASSES,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned RUN_CYCLES = LENET_RUN_CYCLES,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  input  logic [PIXELS*PIX_W-1:0]   frame_data,
  input  logic [LABEL_W-1:0]        frame_label,
  output logic                      core_reset,
  output logic [PIXELS*PIX_W-1:0]   core_input,
  input  logic [LABEL_W-1:0]        core_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [LABEL_W-1:0]        res_class,
  output logic [LABEL_W-1:0]        res_label,
  output logic                      res_correct,
  output logic                      res_illegal,
  input  logic                      clear_stats,
  output logic [CNT_W-1:0]          total_count,
  output logic [CNT_W-1:0]          correct_count,
  output logic                      busy
);

  // Down-counter wide enough for the longer of the two phases (at least 1 bit).
  localparam int unsigned MaxCycles = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  seq_state_e         state;
  logic [CntW-1:0]    cnt;
  logic [LABEL_W-1:0] label_q;
  logic               result_legal;
  logic               handshake;

  assign result_legal = class_legal(32'(core_result), N_CLASSES);
  assign handshake    = res_valid & res_ready;

  // Sequencer FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      label_q     <= '0;
      frame_ready <= 1'b1;
      core_reset  <= 1'b1;
      core_input  <= '0;
      res_valid   <= 1'b0;
      res_class   <= '0;
      res_label   <= '0;
      res_correct <= 1'b0;
      res_illegal <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_valid) begin
            state       <= CORE_RST;
            cnt         <= CntW'(RST_CYCLES - 1);
            core_input  <= frame_data;
            label_q     <= frame_label;
            frame_ready <= 1'b0;
            core_reset  <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CORE_RST: begin
          if (cnt == '0) begin
            state      <= RUN;
            cnt        <= CntW'(RUN_CYCLES - 1);
            core_reset <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            // Hold the core in reset while the result waits; the class is already captured.
            state       <= REPORT;
            core_reset  <= 1'b1;
            res_valid   <= 1'b1;
            res_class   <= core_result;
            res_label   <= label_q;
            res_correct <= result_legal && (core_result == label_q);
            res_illegal <= !result_legal;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            frame_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          frame_ready <= 1'b1;
          core_reset  <= 1'b1;
          res_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_total_count (
    .clk   (clk),
    .reset (reset),
    .clear (clear_stats),
    .inc   (handshake),
    .count (total_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_correct_count (
    .clk   (clk),
    .reset (reset),
    .clear (clear_stats),
    .inc   (handshake & res_correct),
    .count (correct_count)
  );

endmodule

// File: tb/tb_lenet_frame_sequencer.sv
// Directed bench for lenet_frame_sequencer with a stub core that echoes core_input[3:0].
module tb_lenet_frame_sequencer;

  localparam int unsigned PIXELS     = 4;
  localparam int unsigned PIX_W      = 16;
  localparam int unsigned LABEL_W    = 4;
  localparam int unsigned N_CLASSES  = 10;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned RUN_CYCLES = 5;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned DW         = PIXELS * PIX_W;

  logic               clk;
  logic               reset;
  logic               frame_valid;
  logic               frame_ready;
  logic [DW-1:0]      frame_data;
  logic [LABEL_W-1:0] frame_label;
  logic               core_reset;
  logic [DW-1:0]      core_input;
  logic [LABEL_W-1:0] core_result;
  logic               res_valid;
  logic               res_ready;
  logic [LABEL_W-1:0] res_class;
  logic [LABEL_W-1:0] res_label;
  logic               res_correct;
  logic               res_illegal;
  logic               clear_stats;
  logic [CNT_W-1:0]   total_count;
  logic [CNT_W-1:0]   correct_count;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Stub core: reports the low nibble of its input once out of reset.
  assign core_result = core_reset ? 4'hF : core_input[3:0];

  lenet_frame_sequencer #(
    .PIXELS     (PIXELS),
    .PIX_W      (PIX_W),
    .LABEL_W    (LABEL_W),
    .N_CLASSES  (N_CLASSES),
    .RST_CYCLES (RST_CYCLES),
    .RUN_CYCLES (RUN_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_data    (frame_data),
    .frame_label   (frame_label),
    .core_reset    (core_reset),
    .core_input    (core_input),
    .core_result   (core_result),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_class     (res_class),
    .res_label     (res_label),
    .res_correct   (res_correct),
    .res_illegal   (res_illegal),
    .clear_stats   (clear_stats),
    .total_count   (total_count),
    .correct_count (correct_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int tot, input int cor);
    check({tag, "_total"}, 64'(total_count), 64'(tot));
    check({tag, "_correct"}, 64'(correct_count), 64'(cor));
  endtask

  // Offer a frame, wait for its result and check latency and result fields.
  // Returns in the first res_valid cycle; the caller decides the handshake.
  task automatic do_frame(input logic [63:0] d, input logic [3:0] lab, input logic [3:0] cls,
                          input logic cor, input logic ill, input string tag);
    int w;
    int lat;
    frame_data  = d;
    frame_label = lab;
    frame_valid = 1'b1;
    w = 0;
    while (!frame_ready && w < 30) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 64'(frame_ready), 64'(1));
    tick();
    frame_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(8));
    check({tag, "_class"}, 64'(res_class), 64'(cls));
    check({tag, "_label"}, 64'(res_label), 64'(lab));
    check({tag, "_res_correct"}, 64'(res_correct), 64'(cor));
    check({tag, "_res_illegal"}, 64'(res_illegal), 64'(ill));
  endtask

  initial begin
    logic [63:0] bb_data [3];
    int          acc_t [3];
    logic [3:0]  got_cls [3];
    int          nacc;
    int          nres;
    int          cyc;

    reset       = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    frame_label = '0;
    res_ready   = 1'b0;
    clear_stats = 1'b0;
    tick();
    // frame_valid must be ignored while reset is high
    frame_valid = 1'b1;
    frame_data  = 64'h3;
    tick();
    check("rst_frame_ready", 64'(frame_ready), 64'(1));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_core_input", 64'(core_input), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_class", 64'(res_class), 64'(0));
    check("rst_res_label", 64'(res_label), 64'(0));
    check("rst_res_correct", 64'(res_correct), 64'(0));
    check("rst_res_illegal", 64'(res_illegal), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check_counts("rst", 0, 0);
    frame_valid = 1'b0;
    reset       = 1'b0;
    tick();

    // Single frame with a cycle-by-cycle profile of core_reset and res_valid
    frame_data  = 64'h0000_0000_0000_0003;
    frame_label = 4'd3;
    frame_valid = 1'b1;
    res_ready   = 1'b1;
    tick();
    frame_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 7) check("single_core_reset", 64'(core_reset), 64'(c <= 2));
      check("single_res_valid", 64'(res_valid), 64'(c == 8));
      check("single_frame_ready", 64'(frame_ready), 64'(0));
      check("single_busy", 64'(busy), 64'(1));
      if (c < 8) tick();
    end
    check("single_class", 64'(res_class), 64'(3));
    check("single_label", 64'(res_label), 64'(3));
    check("single_res_correct", 64'(res_correct), 64'(1));
    check("single_res_illegal", 64'(res_illegal), 64'(0));
    tick();
    check("single_idle_ready", 64'(frame_ready), 64'(1));
    check_counts("single", 1, 1);

    // Match, mismatch, illegal class
    do_frame(64'h2, 4'd2, 4'd2, 1'b1, 1'b0, "match");
    tick();
    check_counts("match", 2, 2);
    do_frame(64'h1, 4'd2, 4'd1, 1'b0, 1'b0, "mismatch");
    tick();
    check_counts("mismatch", 3, 2);
    do_frame(64'hC, 4'd12, 4'd12, 1'b0, 1'b1, "illegal");
    tick();
    check_counts("illegal", 4, 2);

    // Backpressure: result held, new frame refused
    res_ready = 1'b0;
    do_frame(64'h5, 4'd5, 4'd5, 1'b1, 1'b0, "bp");
    frame_valid = 1'b1;
    frame_data  = 64'hA;
    frame_label = 4'd10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_res_valid", 64'(res_valid), 64'(1));
      check("bp_res_class", 64'(res_class), 64'(5));
      check("bp_res_label", 64'(res_label), 64'(5));
      check("bp_res_correct", 64'(res_correct), 64'(1));
      check("bp_frame_ready", 64'(frame_ready), 64'(0));
    end
    check("bp_core_input", 64'(core_input), 64'h5);
    frame_valid = 1'b0;
    res_ready   = 1'b1;
    tick();
    check("bp_released", 64'(res_valid), 64'(0));
    check_counts("bp", 5, 3);

    // Saturation: clear, then 9 correct frames on a 3-bit counter
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check_counts("clr", 0, 0);
    for (int i = 0; i < 9; i++) begin
      do_frame(64'h7, 4'd7, 4'd7, 1'b1, 1'b0, "sat");
      tick();
    end
    check_counts("sat", 7, 7);

    // Clear coincident with a handshake wins
    res_ready = 1'b0;
    do_frame(64'h4, 4'd4, 4'd4, 1'b1, 1'b0, "clrhs");
    clear_stats = 1'b1;
    res_ready   = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clrhs_res_valid", 64'(res_valid), 64'(0));
    check_counts("clrhs", 0, 0);
    do_frame(64'h6, 4'd6, 4'd6, 1'b1, 1'b0, "post_clr");
    tick();
    check_counts("post_clr", 1, 1);

    // Mid-run reset at cycle 4 after accept
    frame_data  = 64'h8;
    frame_label = 4'd8;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_frame_ready", 64'(frame_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_res_valid", 64'(res_valid), 64'(0));
    check("abort_core_reset", 64'(core_reset), 64'(1));
    check_counts("abort", 0, 0);
    reset = 1'b0;
    tick();
    do_frame(64'h9, 4'd9, 4'd9, 1'b1, 1'b0, "after_abort");
    tick();
    check_counts("after_abort", 1, 1);

    // Back-to-back frames with frame_valid held high
    bb_data[0]  = 64'h1;
    bb_data[1]  = 64'h2;
    bb_data[2]  = 64'h3;
    nacc        = 0;
    nres        = 0;
    cyc         = 0;
    frame_valid = 1'b1;
    while (nres < 3 && cyc < 80) begin
      if (res_valid) begin
        got_cls[nres] = res_class;
        nres++;
      end
      if (frame_ready && nacc < 3) begin
        frame_data    = bb_data[nacc];
        frame_label   = bb_data[nacc][3:0];
        acc_t[nacc]   = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (nacc == 3) frame_valid = 1'b0;
    end
    check("b2b_results", 64'(nres), 64'(3));
    check("b2b_accepts", 64'(nacc), 64'(3));
    if (nacc == 3) begin
      check("b2b_gap01", 64'(acc_t[1] - acc_t[0]), 64'(9));
      check("b2b_gap12", 64'(acc_t[2] - acc_t[1]), 64'(9));
    end
    if (nres == 3) begin
      check("b2b_class0", 64'(got_cls[0]), 64'(1));
      check("b2b_class1", 64'(got_cls[1]), 64'(2));
      check("b2b_class2", 64'(got_cls[2]), 64'(3));
    end
    tick();
    check_counts("b2b", 4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lenet_frame_sequencer.md
# lenet_frame_sequencer

Synthesizable frame sequencer between an image source and the `Lenet` core. It accepts one flattened image plus its label per valid/ready handshake and holds it on the core input. It then pulses the core reset, waits a fixed inference window, and captures the class output. It reports each result over a second handshake and keeps saturating total/correct counters, which moves the image-by-image accuracy run on-chip with parametrised frame size, timing and class count.

## Interface
- `PIXELS`, 1024, pixels per frame (32x32)
- `PIX_W`, 16, bits per pixel (half-precision word)
- `LABEL_W`, 4, width of label and class index
- `N_CLASSES`, 10, legal class count; valid indices are 0..N_CLASSES-1
- `RST_CYCLES`, 1, cycles `core_reset` is held high per frame (>=1)
- `RUN_CYCLES`, 75720, cycles the core runs before its output is sampled (>=1)
- `CNT_W`, 16, statistics counter width
- `clk` in 1, single clock, rising edge
- `reset` in 1, synchronous, active-high
- `frame_valid` in 1, source offers a frame
- `frame_ready` out 1, sequencer can accept a frame
- `frame_data` in PIXELS*PIX_W, flattened image; pixel 0 in the LSBs
- `frame_label` in LABEL_W, expected class
- `core_reset` out 1, drives the `reset` input of `Lenet`
- `core_input` out PIXELS*PIX_W, drives `CNNinput` of `Lenet`
- `core_result` in LABEL_W, from `LeNetoutput` of `Lenet`
- `res_valid` out 1, result available
- `res_ready` in 1, consumer takes result
- `res_class` out LABEL_W, captured core output
- `res_label` out LABEL_W, label of that frame
- `res_correct` out 1, the class is legal and equals the label
- `res_illegal` out 1, the class is >= N_CLASSES
- `clear_stats` in 1, zero both counters
- `total_count` out CNT_W, results delivered
- `correct_count` out CNT_W, correct results delivered
- `busy` out 1, the state is not IDLE

## Operation
- States:
  - IDLE: `frame_ready`=1, `core_reset`=1.
  - CORE_RST: `core_reset`=1 while a down-counter runs.
  - RUN: `core_reset`=0 while a down-counter runs.
  - REPORT: `res_valid`=1.
- Transitions:
  - IDLE -> CORE_RST on `frame_valid & frame_ready`. On this transition `frame_data` latches into `core_input`, `frame_label` latches into a label register, and the counter loads RST_CYCLES-1.
  - CORE_RST -> RUN when the counter is 0. The counter then loads RUN_CYCLES-1.
  - RUN -> REPORT when the counter is 0. On this transition `core_result` is registered into `res_class`, and `res_correct`/`res_illegal` are computed from the registered values.
  - REPORT -> IDLE on `res_ready`.
- `core_input` holds its value outside the accept event.
- Counters saturate at all-ones and increment only on the REPORT -> IDLE handshake:
  - `total_count` always increments.
  - `correct_count` increments when `res_correct`=1.
- `clear_stats` zeros both counters and has priority over a coincident increment; that increment is discarded.
- `res_illegal` frames count as incorrect.
- Reset mid-operation aborts the frame: the state returns to IDLE, no result is issued and the counters are zeroed.

## Timing
- Reset values:
  - state IDLE; `frame_ready`=1 after the reset edge.
  - `core_reset`=1, `core_input`=0.
  - `res_valid`=0, `res_class`=0, `res_label`=0, `res_correct`=0, `res_illegal`=0.
  - both counters 0; `busy`=0.
- `frame_valid` is ignored while `reset`=1.
- Accept at edge E0:
  - `core_reset` stays high for cycles 1..RST_CYCLES.
  - `core_reset` is low for cycles RST_CYCLES+1..RST_CYCLES+RUN_CYCLES.
  - `res_valid` rises at cycle RST_CYCLES+RUN_CYCLES+1.
- Latency from accept to `res_valid` is RST_CYCLES+RUN_CYCLES+1 cycles.
- `res_*` outputs are stable while `res_valid` is high and `res_ready` is low.
- `frame_ready` is low from E0 until the cycle after the result handshake. Back-to-back frames therefore have one IDLE cycle minimum: throughput is 1 frame per RST_CYCLES+RUN_CYCLES+2 cycles.
- All outputs are registered or decoded only from state; there are no combinational in-to-out paths.

## Structure
- Package `cnn_seq_pkg` holds:
  - the state enum (IDLE, CORE_RST, RUN, REPORT);
  - the default constants `LENET_PIXELS`=1024, `LENET_PIX_W`=16, `LENET_RUN_CYCLES`=75720, `LENET_CLASSES`=10.
- One sub-module, `sat_counter` (parameter W; inputs clear, inc; output count). It is instantiated twice, for `total_count` and `correct_count`.
- Derive the down-counter width with `$clog2` of max(RST_CYCLES, RUN_CYCLES).

## Test plan
Bench setup for all scenarios: PIXELS=4, PIX_W=16, RST_CYCLES=2, RUN_CYCLES=5, CNT_W=3, and a stub core that outputs `core_input[3:0]` when `core_reset`=0 and 0xF otherwise.
- Single frame: data=0x0000_0000_0000_0003, label=3, `res_ready`=1.
  - `core_reset` is high for 2 cycles, then low for 5.
  - `res_valid` rises 8 cycles after accept with class=3 and `res_correct`=1.
  - Counters read total=1, correct=1.
- Mismatch and illegal class:
  - label=2, data LSB nibble=2 -> correct=1, counters increment.
  - label=2, data LSB nibble=1 -> `res_correct`=0; `correct_count` is unchanged, `total_count` increments.
  - nibble=12 -> `res_illegal`=1 and `res_correct`=0.
- Backpressure: `res_ready`=0 for 10 cycles.
  - `res_*` outputs are held stable and `frame_ready`=0 throughout.
  - A frame offered meanwhile is not accepted.
- Saturation and clear:
  - 9 correct frames -> both counters read 7.
  - `clear_stats` asserted on the same cycle as a handshake -> both counters read 0.
- Mid-run reset: assert `reset` at cycle 4 after accept.
  - Next cycle: IDLE, `res_valid`=0, `core_reset`=1, counters 0.
  - A new frame is then accepted normally.
- Back-to-back: `frame_valid` held high for 3 frames with `res_ready`=1.
  - Accepts are spaced exactly 9 cycles apart.
  - The 3 results arrive in order.
